// File: rtl/tag_window_controller.sv
// Tag window controller: arms on a trigger channel, forwards tags that fall
// inside [trigger time, trigger time + duration) through a registered stream.
module tag_window_controller #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_tvalid,
  output logic                                s_tready,
  input  logic [WORD_WIDTH-1:0]               s_tkeep,
  input  logic [WORD_WIDTH*TIME_WIDTH-1:0]    s_tagtime,
  input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] s_channel,
  input  logic [TIME_WIDTH-1:0]               s_lowest_time_bound,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [WORD_WIDTH-1:0]               m_tkeep,
  output logic [WORD_WIDTH*TIME_WIDTH-1:0]    m_tagtime,
  output logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] m_channel,
  output logic [TIME_WIDTH-1:0]               m_lowest_time_bound,
  input  logic                                cfg_start,
  input  logic                                cfg_abort,
  input  logic [CHANNEL_WIDTH-1:0]            cfg_trigger_channel,
  input  logic [TIME_WIDTH-1:0]               cfg_duration,
  output logic                                busy,
  output logic                                done,
  output logic [TIME_WIDTH-1:0]               window_start,
  output logic [31:0]                         tag_count
);

  typedef enum logic [1:0] {
    IDLE, ARMED, ACTIVE, DONE
  } state_t;

  state_t                             state_q, state_d;
  logic [CHANNEL_WIDTH-1:0]           trig_q, trig_d;
  logic [TIME_WIDTH-1:0]              dur_q, dur_d;
  logic [TIME_WIDTH-1:0]              wstart_q, wstart_d;
  logic [TIME_WIDTH-1:0]              wend_q, wend_d;
  logic [31:0]                        cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]              mkeep_q, mkeep_d;
  logic [WORD_WIDTH*TIME_WIDTH-1:0]   mtime_q, mtime_d;
  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] mchan_q, mchan_d;
  logic [TIME_WIDTH-1:0]              mltb_q, mltb_d;

  logic                     accept;
  logic [WORD_WIDTH-1:0]    lane_keep;
  logic [31:0]              lane_cnt;
  logic [TIME_WIDTH-1:0]    lane_ws;
  logic [TIME_WIDTH-1:0]    lane_we;
  logic                     lane_act;
  logic                     lane_end;
  logic                     lane_armed;
  logic [TIME_WIDTH-1:0]    lane_t;
  logic [CHANNEL_WIDTH-1:0] lane_c;

  assign m_tvalid = |mkeep_q;
  assign s_tready = m_tready || !m_tvalid;
  assign accept   = s_tvalid && s_tready;

  // Lanes walk in time order; a trigger switches later lanes to window rules.
  always_comb begin
    lane_keep  = '0;
    lane_cnt   = cnt_q;
    lane_ws    = wstart_q;
    lane_we    = wend_q;
    lane_act   = (state_q == ACTIVE);
    lane_armed = (state_q == ARMED);
    lane_end   = 1'b0;
    lane_t     = '0;
    lane_c     = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      lane_t = s_tagtime[i*TIME_WIDTH +: TIME_WIDTH];
      lane_c = s_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      if (s_tkeep[i]) begin
        if (lane_armed && !lane_act && lane_c == trig_q) begin
          lane_act = 1'b1;
          lane_ws  = lane_t;
          lane_we  = lane_t + dur_q;
        end
        if (lane_act) begin
          if (lane_t < lane_we) begin
            lane_keep[i] = 1'b1;
            if (lane_cnt != '1) lane_cnt = lane_cnt + 32'd1;
          end else begin
            lane_end = 1'b1;
          end
        end
      end
    end
    if (lane_act && s_lowest_time_bound >= lane_we) lane_end = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    trig_d   = trig_q;
    dur_d    = dur_q;
    wstart_d = wstart_q;
    wend_d   = wend_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d = ARMED;
          cnt_d   = '0;
          trig_d  = cfg_trigger_channel;
          dur_d   = cfg_duration;
        end
      end
      ARMED, ACTIVE: begin
        if (accept) begin
          cnt_d    = lane_cnt;
          wstart_d = lane_ws;
          wend_d   = lane_we;
          if (lane_end)      state_d = DONE;
          else if (lane_act) state_d = ACTIVE;
        end
        if (cfg_abort) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mkeep_d = mkeep_q;
    mtime_d = mtime_q;
    mchan_d = mchan_q;
    mltb_d  = mltb_q;
    if (accept) begin
      mkeep_d = lane_keep;
      mtime_d = s_tagtime;
      mchan_d = s_channel;
      mltb_d  = s_lowest_time_bound;
    end else if (m_tready) begin
      mkeep_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trig_q   <= '0;
      dur_q    <= '0;
      wstart_q <= '0;
      wend_q   <= '0;
      cnt_q    <= '0;
      mkeep_q  <= '0;
      mtime_q  <= '0;
      mchan_q  <= '0;
      mltb_q   <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_d;
      dur_q    <= dur_d;
      wstart_q <= wstart_d;
      wend_q   <= wend_d;
      cnt_q    <= cnt_d;
      mkeep_q  <= mkeep_d;
      mtime_q  <= mtime_d;
      mchan_q  <= mchan_d;
      mltb_q   <= mltb_d;
    end
  end

  assign m_tkeep             = mkeep_q;
  assign m_tagtime           = mtime_q;
  assign m_channel           = mchan_q;
  assign m_lowest_time_bound = mltb_q;
  assign busy                = (state_q != IDLE);
  assign done                = (state_q == DONE);
  assign window_start        = wstart_q;
  assign tag_count           = cnt_q;

endmodule

// File: tb/tb_tag_window_controller.sv
// Bench for tag_window_controller: directed vector table, backpressure and
// reset sequences, then random traffic against a behavioural window model.
module tb_tag_window_controller;
  localparam int WW = 4;
  localparam int TW = 64;
  localparam int CW = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_tvalid, s_tready;
  logic [WW-1:0]      s_tkeep;
  logic [WW*TW-1:0]   s_tagtime;
  logic [WW*CW-1:0]   s_channel;
  logic [TW-1:0]      s_ltb;
  logic               m_tvalid, m_tready;
  logic [WW-1:0]      m_tkeep;
  logic [WW*TW-1:0]   m_tagtime;
  logic [WW*CW-1:0]   m_channel;
  logic [TW-1:0]      m_ltb;
  logic               cfg_start, cfg_abort;
  logic [CW-1:0]      cfg_trig;
  logic [TW-1:0]      cfg_dur;
  logic               busy, done;
  logic [TW-1:0]      window_start;
  logic [31:0]        tag_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tag_window_controller #(.WORD_WIDTH(WW), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tkeep(s_tkeep),
    .s_tagtime(s_tagtime), .s_channel(s_channel),
    .s_lowest_time_bound(s_ltb),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tkeep(m_tkeep),
    .m_tagtime(m_tagtime), .m_channel(m_channel),
    .m_lowest_time_bound(m_ltb),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_trigger_channel(cfg_trig), .cfg_duration(cfg_dur),
    .busy(busy), .done(done), .window_start(window_start),
    .tag_count(tag_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 60)
        $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic             start;
    logic             abort;
    logic [CW-1:0]    trig;
    logic [TW-1:0]    dur;
    logic             valid;
    logic [3:0]       keep;
    logic [3:0][63:0] t;
    logic [3:0][5:0]  ch;
    logic [63:0]      ltb;
    logic [3:0]       e_keep;
    logic             e_busy;
    logic             e_done;
    logic [31:0]      e_cnt;
    logic [63:0]      e_ws;
    logic [63:0]      e_ltb;
  } vec_t;

  vec_t vt[$];

  function automatic logic [3:0][63:0] t4(input longint a, b, c, d);
    logic [3:0][63:0] r;
    r[0] = 64'(a); r[1] = 64'(b); r[2] = 64'(c); r[3] = 64'(d);
    return r;
  endfunction

  function automatic logic [3:0][5:0] c4(input int a, b, c, d);
    logic [3:0][5:0] r;
    r[0] = 6'(a); r[1] = 6'(b); r[2] = 6'(c); r[3] = 6'(d);
    return r;
  endfunction

  function automatic vec_t mk(
    input bit st, input bit ab, input int tr, input longint du,
    input bit va, input logic [3:0] kp,
    input logic [3:0][63:0] t, input logic [3:0][5:0] ch, input longint lb,
    input logic [3:0] ek, input bit eb, input bit ed,
    input int ec, input longint ews, input longint elb);
    vec_t v;
    v.start = st; v.abort = ab; v.trig = 6'(tr); v.dur = 64'(du);
    v.valid = va; v.keep = kp; v.t = t; v.ch = ch; v.ltb = 64'(lb);
    v.e_keep = ek; v.e_busy = eb; v.e_done = ed;
    v.e_cnt = 32'(ec); v.e_ws = 64'(ews); v.e_ltb = 64'(elb);
    return v;
  endfunction

  task automatic idle_inputs();
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_trig = '0; cfg_dur = '0;
    s_tvalid = 1'b0; s_tkeep = '0; s_tagtime = '0; s_channel = '0; s_ltb = '0;
  endtask

  task automatic word(input logic [3:0] kp, input logic [3:0][63:0] t,
                      input logic [3:0][5:0] ch, input longint lb);
    s_tvalid = 1'b1; s_tkeep = kp; s_tagtime = t; s_channel = ch; s_ltb = 64'(lb);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // behavioural model state for the random phase
  int               md;
  logic [CW-1:0]    r_trig;
  logic [63:0]      r_dur, r_ws, r_we, r_ltb;
  logic [31:0]      r_cnt;
  logic [3:0]       r_keep;
  logic [WW*TW-1:0] r_time;
  logic [WW*CW-1:0] r_chan;

  initial begin
    vec_t v;
    logic [3:0][63:0] tz;
    logic [3:0][5:0]  cz;
    tz = t4(0, 0, 0, 0);
    cz = c4(0, 0, 0, 0);
    rst_n = 1'b0;
    m_tready = 1'b1;
    idle_inputs();

    // directed table: each row is one clock edge, checked just after it
    vt.push_back(mk(1,0, 3,1000, 0,4'h0, tz, cz, 0,     4'h0,1,0,0,0,0));
    vt.push_back(mk(0,0, 0,0, 1,4'hF, t4(100,200,300,400), c4(1,3,2,5), 100,
                    4'hE,1,0,3,200,100));
    vt.push_back(mk(0,0, 0,0, 1,4'hF, t4(900,1199,1200,1300), c4(1,1,1,1), 900,
                    4'h3,1,1,5,200,900));
    vt.push_back(mk(0,0, 0,0, 0,4'h0, tz, cz, 0,     4'h0,0,0,5,200,900));
    vt.push_back(mk(1,0,-2,0, 0,4'h0, tz, cz, 0,     4'h0,1,0,0,200,900));
    vt.push_back(mk(0,0, 0,0, 1,4'hF, t4(2000,2100,2200,2300), c4(1,-2,-2,3), 2000,
                    4'h0,1,1,0,2100,2000));
    vt.push_back(mk(0,0, 0,0, 0,4'h0, tz, cz, 0,     4'h0,0,0,0,2100,2000));
    vt.push_back(mk(1,0, 5,500, 0,4'h0, tz, cz, 0,   4'h0,1,0,0,2100,2000));
    vt.push_back(mk(0,0, 0,0, 1,4'h1, t4(3000,0,0,0), c4(5,0,0,0), 3000,
                    4'h1,1,0,1,3000,3000));
    vt.push_back(mk(1,0, 1,0, 1,4'h0, tz, cz, 3200,  4'h0,1,0,1,3000,3200));
    vt.push_back(mk(0,0, 0,0, 1,4'h0, tz, cz, 3500,  4'h0,1,1,1,3000,3500));
    vt.push_back(mk(0,0, 0,0, 0,4'h0, tz, cz, 0,     4'h0,0,0,1,3000,3500));
    vt.push_back(mk(1,0, 1,100, 0,4'h0, tz, cz, 0,   4'h0,1,0,0,3000,3500));
    vt.push_back(mk(1,1, 2,0, 1,4'h1, t4(4000,0,0,0), c4(1,0,0,0), 4000,
                    4'h1,0,0,1,4000,4000));
    vt.push_back(mk(0,0, 0,0, 1,4'h1, t4(4050,0,0,0), c4(1,0,0,0), 4050,
                    4'h0,0,0,1,4000,4050));

    #2;
    chk("rst_keep", 64'(m_tkeep), 0);
    chk("rst_mvalid", 64'(m_tvalid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_ws", window_start, 0);
    chk("rst_cnt", 64'(tag_count), 0);
    chk("rst_ltb", m_ltb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vt[i]) begin
      v = vt[i];
      cfg_start = v.start; cfg_abort = v.abort;
      cfg_trig = v.trig; cfg_dur = v.dur;
      s_tvalid = v.valid; s_tkeep = v.keep;
      s_tagtime = v.t; s_channel = v.ch; s_ltb = v.ltb;
      step();
      chk($sformatf("v%0d_keep", i), 64'(m_tkeep), 64'(v.e_keep));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(v.e_busy));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(v.e_done));
      chk($sformatf("v%0d_cnt", i), 64'(tag_count), 64'(v.e_cnt));
      chk($sformatf("v%0d_ws", i), window_start, v.e_ws);
      chk($sformatf("v%0d_ltb", i), m_ltb, v.e_ltb);
      for (int l = 0; l < WW; l++)
        if (v.e_keep[l])
          chk($sformatf("v%0d_t%0d", i, l), m_tagtime[l*TW +: TW], v.t[l]);
    end
    idle_inputs();
    step();

    // downstream stall while a window is open
    cfg_start = 1'b1; cfg_trig = 6'd2; cfg_dur = 64'd10000;
    step();
    cfg_start = 1'b0;
    word(4'hF, t4(5000,5100,5200,5300), c4(2,0,0,0), 5000);
    step();
    chk("bp_keep0", 64'(m_tkeep), 64'hF);
    chk("bp_cnt0", 64'(tag_count), 4);
    m_tready = 1'b0;
    word(4'hF, t4(5400,5500,5600,5700), c4(0,0,0,0), 5400);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_sready", k), 64'(s_tready), 0);
      step();
      chk($sformatf("bp%0d_keep", k), 64'(m_tkeep), 64'hF);
      chk($sformatf("bp%0d_t0", k), m_tagtime[TW-1:0], 5000);
      chk($sformatf("bp%0d_ltb", k), m_ltb, 5000);
      chk($sformatf("bp%0d_cnt", k), 64'(tag_count), 4);
    end
    m_tready = 1'b1;
    #1;
    chk("bp_sready_back", 64'(s_tready), 1);
    step();
    chk("bp_keep1", 64'(m_tkeep), 64'hF);
    chk("bp_t1", m_tagtime[TW-1:0], 5400);
    chk("bp_cnt1", 64'(tag_count), 8);
    idle_inputs();
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    chk("bp_abort_busy", 64'(busy), 0);

    // abort while armed, then reset during an open window
    cfg_start = 1'b1; cfg_trig = 6'd4; cfg_dur = 64'd100;
    step();
    cfg_start = 1'b0; cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    chk("ab_busy", 64'(busy), 0);
    chk("ab_done", 64'(done), 0);
    cfg_start = 1'b1; cfg_dur = 64'd1000;
    step();
    cfg_start = 1'b0;
    word(4'h1, t4(6000,0,0,0), c4(4,0,0,0), 6000);
    step();
    idle_inputs();
    chk("ar_busy", 64'(busy), 1);
    chk("ar_keep", 64'(m_tkeep), 1);
    chk("ar_cnt", 64'(tag_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rst_keep", 64'(m_tkeep), 0);
    chk("ar_rst_busy", 64'(busy), 0);
    chk("ar_rst_done", 64'(done), 0);
    chk("ar_rst_ws", window_start, 0);
    chk("ar_rst_cnt", 64'(tag_count), 0);
    chk("ar_rst_ltb", m_ltb, 0);
    step();
    chk("ar_rst_done2", 64'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_post_done", 64'(done), 0);
    chk("ar_post_busy", 64'(busy), 0);

    // random traffic against the window model
    md = 0; r_trig = '0; r_dur = '0; r_ws = '0; r_we = '0; r_ltb = '0;
    r_cnt = '0; r_keep = '0; r_time = '0; r_chan = '0;
    begin
      longint bt;
      bt = 10000;
      for (int n = 0; n < 3000; n++) begin
        logic       exp_sready, acc, ended;
        logic [3:0] fwd;
        int         nm;
        logic [63:0] lt;
        logic [5:0]  lc;
        logic [3:0][63:0] tt;
        logic [3:0][5:0]  cc;
        int          durs[4];
        int          trs[3];
        durs = '{0, 300, 800, 3000};
        trs = '{1, 2, -1};
        cfg_start = ($urandom_range(0, 9) == 0);
        cfg_abort = ($urandom_range(0, 59) == 0);
        cfg_trig = 6'(trs[$urandom_range(0, 2)]);
        cfg_dur = 64'(durs[$urandom_range(0, 3)]);
        s_tvalid = ($urandom_range(0, 3) != 0);
        m_tready = ($urandom_range(0, 3) != 0);
        s_tkeep = 4'($urandom);
        s_ltb = 64'(bt);
        for (int l = 0; l < WW; l++) begin
          bt += longint'($urandom_range(0, 200));
          tt[l] = 64'(bt);
          cc[l] = 6'(int'($urandom_range(0, 4)) - 2);
        end
        s_tagtime = tt;
        s_channel = cc;
        #1;
        exp_sready = m_tready || (r_keep == 4'h0);
        chk($sformatf("r%0d_sready", n), 64'(s_tready), 64'(exp_sready));
        acc = s_tvalid && exp_sready;
        fwd = 4'h0;
        ended = 1'b0;
        nm = md;
        if (md == 3) begin
          nm = 0;
        end else if (md == 0) begin
          if (cfg_start && !cfg_abort) begin
            nm = 1; r_cnt = '0; r_trig = cfg_trig; r_dur = cfg_dur;
          end
        end else begin
          if (acc) begin
            for (int l = 0; l < WW; l++) begin
              lt = tt[l];
              lc = cc[l];
              if (s_tkeep[l]) begin
                if (nm == 1 && lc == r_trig) begin
                  nm = 2; r_ws = lt; r_we = lt + r_dur;
                end
                if (nm == 2) begin
                  if (lt < r_we) begin
                    fwd[l] = 1'b1;
                    if (r_cnt != 32'hFFFF_FFFF) r_cnt = r_cnt + 1;
                  end else begin
                    ended = 1'b1;
                  end
                end
              end
            end
            if (nm == 2 && s_ltb >= r_we) ended = 1'b1;
            if (ended) nm = 3;
          end
          if (cfg_abort) nm = 0;
        end
        if (acc) begin
          r_keep = fwd; r_time = s_tagtime; r_chan = s_channel; r_ltb = s_ltb;
        end else if (m_tready) begin
          r_keep = 4'h0;
        end
        md = nm;
        @(posedge clk);
        #1;
        chk($sformatf("r%0d_keep", n), 64'(m_tkeep), 64'(r_keep));
        chk($sformatf("r%0d_mvalid", n), 64'(m_tvalid), 64'(r_keep != 0));
        chk($sformatf("r%0d_ltb", n), m_ltb, r_ltb);
        chk($sformatf("r%0d_busy", n), 64'(busy), 64'(md != 0));
        chk($sformatf("r%0d_done", n), 64'(done), 64'(md == 3));
        chk($sformatf("r%0d_cnt", n), 64'(tag_count), 64'(r_cnt));
        chk($sformatf("r%0d_ws", n), window_start, r_ws);
        for (int l = 0; l < WW; l++)
          if (r_keep[l]) begin
            chk($sformatf("r%0d_t%0d", n, l), m_tagtime[l*TW +: TW], r_time[l*TW +: TW]);
            chk($sformatf("r%0d_c%0d", n, l), 64'(m_channel[l*CW +: CW]), 64'(r_chan[l*CW +: CW]));
          end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_window_controller.md
TAG_WINDOW_CONTROLLER -- requirements
Module: tag_window_controller

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 4, meaning tag lanes per stream word.
REQ-002 SHALL have parameter TIME_WIDTH, default 64, meaning tag time width in ps.
REQ-003 SHALL have parameter CHANNEL_WIDTH, default 6, meaning signed channel index width (rising +k, falling -k).
REQ-004 SHALL have clk  input  1  sole clock, 312.5 MHz nominal.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have s_tvalid/s_tready  input/output  1/1  upstream word handshake.
REQ-007 SHALL have s_tkeep  input  WORD_WIDTH  per-lane valid.
REQ-008 SHALL have s_tagtime, s_channel  input  WORD_WIDTH*TIME_WIDTH, WORD_WIDTH*CHANNEL_WIDTH  lane data, lane 0 earliest.
REQ-009 SHALL have s_lowest_time_bound  input  TIME_WIDTH  no later tag will be earlier than this.
REQ-010 SHALL have m_tvalid, m_tready, m_tkeep, m_tagtime, m_channel, m_lowest_time_bound  out/in/out/out/out/out  same widths  gated downstream stream.
REQ-011 SHALL have cfg_start, cfg_abort  input  1 each  single-cycle command pulses.
REQ-012 SHALL have cfg_trigger_channel  input  CHANNEL_WIDTH  signed channel that opens the window.
REQ-013 SHALL have cfg_duration  input  TIME_WIDTH  window length in ps.
REQ-014 SHALL have busy, done  output  1 each  state not IDLE; one-cycle completion pulse.
REQ-015 SHALL have window_start  output  TIME_WIDTH  tagtime of the trigger tag.
REQ-016 SHALL have tag_count  output  32  tags forwarded in current/last window, saturating.

Function
REQ-017 SHALL implement states IDLE, ARMED, ACTIVE, DONE.
REQ-018 SHALL assign s_tready = m_tready || !m_tvalid in every state; m_tvalid = |m_tkeep.
REQ-019 SHALL register output: an accepted input word appears on m_* exactly one cycle after acceptance; m_* held stable while m_tvalid && !m_tready.
REQ-020 SHALL drop lanes not inside the window (tkeep cleared) and never emit a word with m_tkeep all zero; m_tagtime/m_channel of cleared lanes are don't-care.
REQ-021 SHALL update m_lowest_time_bound from s_lowest_time_bound on every accepted cycle, including when all lanes are dropped.
REQ-022 IDLE: all lanes dropped; cfg_start -> ARMED, clears tag_count, samples cfg_trigger_channel and cfg_duration.
REQ-023 ARMED: first lane (lowest index, tkeep=1) whose channel equals sampled trigger sets window_start=its tagtime, window_end=window_start+duration (modulo 2^TIME_WIDTH), -> ACTIVE; that lane and later lanes of the same word evaluated under ACTIVE rule in the same cycle.
REQ-024 ACTIVE: lane forwarded iff tkeep=1 and tagtime < window_end; each forwarded lane increments tag_count (saturate at 2^32-1).
REQ-025 ACTIVE -> DONE when an accepted word contains a kept lane with tagtime >= window_end, or accepted s_lowest_time_bound >= window_end.
REQ-026 DONE: done=1 for exactly one cycle, lanes dropped, -> IDLE next cycle.
REQ-027 cfg_duration=0: trigger lane itself dropped, ARMED -> DONE directly in the trigger cycle.
REQ-028 Further trigger-channel tags in ACTIVE SHALL be treated as ordinary tags.
REQ-029 cfg_start outside IDLE SHALL be ignored.
REQ-030 cfg_abort in ARMED/ACTIVE SHALL -> IDLE next cycle without done; the word accepted in the abort cycle is gated by the pre-abort state; cfg_abort wins over cfg_start.
REQ-031 No state transition or counter update SHALL occur on cycles where s_tvalid && s_tready is false (except abort and DONE->IDLE).

Reset
REQ-032 While rst_n=0: state IDLE, m_tkeep=0, m_lowest_time_bound=0, busy=0, done=0, window_start=0, tag_count=0.
REQ-033 Reset assertion mid-window SHALL abandon the window immediately; no done pulse.
REQ-034 First accepted word SHALL be on the second rising clk edge after rst_n deasserts.

Verification
REQ-035 start, trigger=+3, duration=1000; word tagtimes {100,200,300,400} ch {1,3,2,5} -> m_tkeep=0b1110, window_start=200, tag_count=3.
REQ-036 continuing REQ-035: word tagtimes {900,1199,1200,1300} -> m_tkeep=0b0011, done pulse one cycle later, tag_count=5, busy=0.
REQ-037 ACTIVE, empty words with s_lowest_time_bound=1200 (end 1200) -> DONE, no m_tvalid, m_lowest_time_bound=1200.
REQ-038 m_tready=0 for 5 cycles in ACTIVE -> s_tready=0, m_* stable, tag_count unchanged.
REQ-039 duration=0, trigger found -> no output lane, done pulse, tag_count=0.
REQ-040 cfg_abort in ARMED, then rst_n=0 during later ACTIVE -> IDLE, no done, all outputs at reset values.
